// File: rtl/conv_k_addr_gen_if.sv
// Kernel-weight address bundle between the address generator and its consumer.
// Latency: none (wires only).
// Backpressure: consumer holds enable low to stall the beat in flight.
// Signals: start, enable (consumer -> generator); addr, addr_valid, busy, done
// (generator -> consumer). Extra n_loops / loop_idx exist when CONV_K_ADDR_LOOP_EN
// is defined. The master modport is the generator side.
interface conv_k_addr_gen_if #(
  parameter int ADDR_W  = 8,
  parameter int N_PORTS = 2
);
  logic                        start;
  logic                        enable;
  logic [N_PORTS*ADDR_W-1:0]   addr;
  logic                        addr_valid;
  logic                        busy;
  logic                        done;
`ifdef CONV_K_ADDR_LOOP_EN
  logic [7:0]                  n_loops;
  logic [7:0]                  loop_idx;

  modport master (input start, enable, n_loops,
                  output addr, addr_valid, busy, done, loop_idx);
  modport slave  (output start, enable, n_loops,
                  input addr, addr_valid, busy, done, loop_idx);
`else
  modport master (input start, enable,
                  output addr, addr_valid, busy, done);
  modport slave  (output start, enable,
                  input addr, addr_valid, busy, done);
`endif
endinterface

// File: rtl/conv_k_addr_gen.sv
// Kernel-weight address generator: N_PORTS lockstep streams, port i sweeping
// [i*SEG_LEN, i*SEG_LEN+SEG_LEN-1]. Latency: first beat valid the cycle after start.
// Backpressure: enable=0 holds the current beat (RUN) or freezes the wait count (WAIT).
// Ports: clk, reset (async, active-high), bus (conv_k_addr_gen_if.master):
//   start/enable in; addr (port i at [i*ADDR_W +: ADDR_W]), addr_valid, busy, done out.
// Optional feature macro CONV_K_ADDR_LOOP_EN: adds n_loops in / loop_idx out and
// repeats the sweep n_loops+1 times back-to-back. All outputs come straight from flops.
module conv_k_addr_gen #(
  parameter int ADDR_W   = 8,
  parameter int N_PORTS  = 2,
  parameter int SEG_LEN  = 75,
  parameter int WAIT_CYC = 0
) (
  input  logic               clk,
  input  logic               reset,
  conv_k_addr_gen_if.master  bus
);

  localparam int IDX_W = (SEG_LEN > 1) ? $clog2(SEG_LEN) : 1;
  localparam int WC_W  = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SEG_LEN - 1);
  localparam longint TOP_ADDR = longint'(N_PORTS) * longint'(SEG_LEN) - 1;

  if (SEG_LEN == 0) begin : g_err_len
    $error("conv_k_addr_gen: SEG_LEN must be non-zero");
  end
  if (TOP_ADDR >= (longint'(1) << ADDR_W)) begin : g_err_ovf
    $error("conv_k_addr_gen: N_PORTS*SEG_LEN does not fit in ADDR_W bits");
  end

  // Per-port segment base addresses, also the reset value of the addr bus.
  function automatic logic [N_PORTS*ADDR_W-1:0] base_addrs();
    logic [N_PORTS*ADDR_W-1:0] v;
    v = '0;
    for (int p = 0; p < N_PORTS; p++) v[p*ADDR_W +: ADDR_W] = ADDR_W'(p * SEG_LEN);
    return v;
  endfunction
  localparam logic [N_PORTS*ADDR_W-1:0] ADDR_BASE = base_addrs();

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [WC_W-1:0]           wcnt_q, wcnt_d;
  logic [N_PORTS*ADDR_W-1:0] addr_q, addr_d;
  logic                      addr_valid_q, addr_valid_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
`ifdef CONV_K_ADDR_LOOP_EN
  logic [7:0]                loop_q, loop_d;
  logic [7:0]                nloops_q, nloops_d;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wcnt_d  = wcnt_q;
`ifdef CONV_K_ADDR_LOOP_EN
    loop_d   = loop_q;
    nloops_d = nloops_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_RUN;
          idx_d   = '0;
`ifdef CONV_K_ADDR_LOOP_EN
          loop_d   = 8'd0;
          nloops_d = bus.n_loops;
`endif
        end
      end
      S_RUN: begin
        if (bus.enable) begin
          if (idx_q == IDX_LAST) begin
`ifdef CONV_K_ADDR_LOOP_EN
            // Pass boundary goes straight back to RUN: no wait gap, no idle cycle.
            if (loop_q != nloops_q) begin
              idx_d  = '0;
              loop_d = loop_q + 8'd1;
            end else begin
              state_d = S_DONE;
            end
`else
            state_d = S_DONE;
`endif
          end else if (WAIT_CYC == 0) begin
            idx_d = idx_q + 1'b1;
          end else begin
            state_d = S_WAIT;
            wcnt_d  = WC_W'(WAIT_CYC - 1);
          end
        end
      end
      S_WAIT: begin
        // Wait cycles only elapse while the consumer is enabled.
        if (bus.enable) begin
          if (wcnt_q == '0) begin
            state_d = S_RUN;
            idx_d   = idx_q + 1'b1;
          end else begin
            wcnt_d = wcnt_q - 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are precomputed from next state so they leave the flops directly.
    for (int p = 0; p < N_PORTS; p++)
      addr_d[p*ADDR_W +: ADDR_W] = ADDR_BASE[p*ADDR_W +: ADDR_W] + ADDR_W'(idx_d);
    addr_valid_d = (state_d == S_RUN);
    busy_d       = (state_d == S_RUN) || (state_d == S_WAIT);
    done_d       = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      wcnt_q       <= '0;
      addr_q       <= ADDR_BASE;
      addr_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef CONV_K_ADDR_LOOP_EN
      loop_q       <= 8'd0;
      nloops_q     <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      wcnt_q       <= wcnt_d;
      addr_q       <= addr_d;
      addr_valid_q <= addr_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef CONV_K_ADDR_LOOP_EN
      loop_q       <= loop_d;
      nloops_q     <= nloops_d;
`endif
    end
  end

  assign bus.addr       = addr_q;
  assign bus.addr_valid = addr_valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
`ifdef CONV_K_ADDR_LOOP_EN
  assign bus.loop_idx   = loop_q;
`endif

endmodule

// File: tb/tb_conv_k_addr_gen.sv
// Bench for conv_k_addr_gen: default instance under random start/enable against a
// beat-count model, plus a WAIT_CYC=2 instance and a 4-port SEG_LEN=64 instance.
// Backpressure: enable is randomized on the default instance.
module tb_conv_k_addr_gen;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  conv_k_addr_gen_if #(.ADDR_W(8), .N_PORTS(2)) k0 ();
  conv_k_addr_gen_if #(.ADDR_W(8), .N_PORTS(2)) k1 ();
  conv_k_addr_gen_if #(.ADDR_W(8), .N_PORTS(4)) k2 ();

  conv_k_addr_gen #(.ADDR_W(8), .N_PORTS(2), .SEG_LEN(75), .WAIT_CYC(0))
    u_dut0 (.clk(clk), .reset(reset), .bus(k0));
  conv_k_addr_gen #(.ADDR_W(8), .N_PORTS(2), .SEG_LEN(75), .WAIT_CYC(2))
    u_dut1 (.clk(clk), .reset(reset), .bus(k1));
  conv_k_addr_gen #(.ADDR_W(8), .N_PORTS(4), .SEG_LEN(64), .WAIT_CYC(0))
    u_dut2 (.clk(clk), .reset(reset), .bus(k2));

`ifdef CONV_K_ADDR_LOOP_EN
  assign k0.n_loops = 8'd0;
  assign k1.n_loops = 8'd0;
  assign k2.n_loops = 8'd0;
`endif

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model for the default instance: a sweep is 75 accepted beats.
  bit m_active = 0;
  bit m_done   = 0;
  int m_beats  = 0;

  task automatic check_dut0(input string tag);
    int idx;
    idx = (m_beats > 74) ? 74 : m_beats;
    check_eq({tag, ".valid"}, k0.addr_valid, m_active);
    check_eq({tag, ".busy"},  k0.busy,       m_active);
    check_eq({tag, ".done"},  k0.done,       m_done);
    check_eq({tag, ".addr0"}, k0.addr[7:0],  idx);
    check_eq({tag, ".addr1"}, k0.addr[15:8], 75 + idx);
  endtask

  // Called at a falling edge: check, apply inputs for the next rising edge, advance model.
  task automatic cyc0(input string tag, input bit st, input bit en);
    check_dut0(tag);
    k0.start  = st;
    k0.enable = en;
    if (m_active) begin
      if (en) begin
        m_beats++;
        if (m_beats == 75) begin
          m_active = 0;
          m_done   = 1;
        end
      end
    end else if (st) begin
      m_active = 1;
      m_done   = 0;
      m_beats  = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    k0.start = 0; k0.enable = 0;
    k1.start = 0; k1.enable = 0;
    k2.start = 0; k2.enable = 0;
    repeat (2) @(negedge clk);

    // Reset values
    check_dut0("rst");
    for (int p = 0; p < 4; p++) check_eq("rst.k2addr", k2.addr[p*8 +: 8], p * 64);
    check_eq("rst.k1valid", k1.addr_valid, 0);
    reset = 1'b0;
    @(negedge clk);

    // Full sweep, enable high; done must then hold
    cyc0("t1", 1, 1);
    repeat (85) cyc0("t1", 0, 1);

    // Start while done restarts at 0; start at idx 20 is ignored
    cyc0("t5", 1, 1);
    while (m_beats != 20) cyc0("t5", 0, 1);
    cyc0("t5ign", 1, 1);
    repeat (60) cyc0("t5", 0, 1);

    // Random start/enable
    repeat (600) cyc0("rnd", ($urandom % 20) == 0, ($urandom % 4) != 0);

    // Stall for three cycles at idx 10
    for (int i = 0; i < 400 && m_active; i++) cyc0("t2pre", 0, ($urandom % 4) != 0);
    cyc0("t2", 1, 1);
    while (m_beats != 10) cyc0("t2", 0, 1);
    repeat (3) cyc0("t2hold", 0, 0);
    repeat (70) cyc0("t2", 0, 1);

    // Async reset mid-sweep at idx 40
    cyc0("t4", 1, 1);
    while (m_beats != 40) cyc0("t4", 0, 1);
    check_dut0("t4pre");
    reset = 1'b1;
    #1;
    m_active = 0; m_done = 0; m_beats = 0;
    check_dut0("t4rst");
    @(negedge clk);
    reset = 1'b0;
    cyc0("t4new", 1, 1);
    repeat (80) cyc0("t4new", 0, 1);

    // WAIT_CYC=2 instance: beat every third cycle
    k1.start = 1; k1.enable = 1;
    @(negedge clk);
    k1.start = 0;
    for (int c = 0; c < 230; c++) begin
      int idx;
      idx = (c <= 222) ? c / 3 : 74;
      check_eq("t3.valid", k1.addr_valid, (c <= 222) && (c % 3 == 0));
      check_eq("t3.busy",  k1.busy, c <= 222);
      check_eq("t3.done",  k1.done, c >= 223);
      check_eq("t3.addr0", k1.addr[7:0], idx);
      check_eq("t3.addr1", k1.addr[15:8], 75 + idx);
      @(negedge clk);
    end

    // Four-port instance filling the whole 8-bit space
    k2.start = 1; k2.enable = 1;
    @(negedge clk);
    k2.start = 0;
    for (int c = 0; c < 70; c++) begin
      int idx;
      idx = (c < 64) ? c : 63;
      check_eq("t7.valid", k2.addr_valid, c < 64);
      check_eq("t7.done",  k2.done, c >= 64);
      for (int p = 0; p < 4; p++) check_eq("t7.addr", k2.addr[p*8 +: 8], p * 64 + idx);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
